// File: rtl/dds_key_cmd_ctrl_if.sv
// Configuration bus from the key command controller to the DDS core.
// The master offers a frequency word, waveform and amplitude shift under valid/ready.
interface dds_key_cmd_ctrl_if #(
  parameter int FW = 32
);
  logic          cfg_valid;
  logic          cfg_ready;
  logic [FW-1:0] freq_word;
  logic [1:0]    wave_sel;
  logic [1:0]    amp_shift;

  modport master (
    output cfg_valid, freq_word, wave_sel, amp_shift,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, freq_word, wave_sel, amp_shift,
    output cfg_ready
  );
endinterface

// File: rtl/dds_key_cmd_ctrl.sv
// Key pulses -> queued DDS configuration updates, serviced one at a time over valid/ready.
// Optional step acceleration for repeated up/dn presses: define DDS_KEY_STEP_ACCEL_EN.
module dds_key_cmd_ctrl #(
  parameter int          FW      = 32,
  parameter int unsigned STEP    = 85_899,
  parameter int unsigned FMIN    = 85_899,
  parameter int unsigned FMAX    = 429_496_730,
  parameter int unsigned FRESET  = 85_899,
  parameter int unsigned ACC_WIN = 25_000_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 key_up_i,
  input  logic                 key_dn_i,
  input  logic                 key_wave_i,
  input  logic                 key_amp_i,
  dds_key_cmd_ctrl_if.master   cfg_if,
  output logic                 busy_o,
  output logic                 drop_o
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_SEND} state_e;
  typedef enum logic [1:0] {C_UP, C_DN, C_WAVE, C_AMP} cmd_e;

  localparam logic [FW:0]   STEP_W   = (FW+1)'(STEP);
  localparam logic [FW:0]   FMIN_W   = (FW+1)'(FMIN);
  localparam logic [FW:0]   FMAX_W   = (FW+1)'(FMAX);
  localparam logic [FW-1:0] FRESET_W = FW'(FRESET);
  localparam logic [24:0]   ACC_WIN_W = 25'(ACC_WIN);

  state_e        state_q, state_d;
  cmd_e          cmd_q, cmd_d;
  logic [3:0]    pending_q, pending_d;
  logic [FW-1:0] freq_q, freq_d;
  logic [1:0]    wave_q, wave_d;
  logic [1:0]    amp_q, amp_d;
  logic          drop_q, drop_d;

  logic [3:0]    key_vec;
  logic [3:0]    clr_vec;
  logic [FW:0]   step_w;
  logic [FW:0]   up_sum;
  logic [FW:0]   dn_floor;
  logic [FW-1:0] up_val;
  logic [FW-1:0] dn_val;

  // Bit order matches service priority: up, dn, wave, amp.
  assign key_vec = {key_up_i, key_dn_i, key_wave_i, key_amp_i};

`ifdef DDS_KEY_STEP_ACCEL_EN
  logic [24:0] win_cnt_q;
  logic [1:0]  mult_sh_q;
  logic [1:0]  mult_sh_eff;
  logic        last_dn_q;
  logic        same_dir;
  logic        updn_calc;

  assign updn_calc   = (state_q == S_CALC) && ((cmd_q == C_UP) || (cmd_q == C_DN));
  assign same_dir    = (last_dn_q == (cmd_q == C_DN)) && (win_cnt_q < ACC_WIN_W);
  assign mult_sh_eff = same_dir ? ((mult_sh_q == 2'd3) ? 2'd3 : mult_sh_q + 2'd1) : 2'd0;
  assign step_w      = STEP_W << mult_sh_eff;

  // Counter parks at ACC_WIN so the first press after reset or a long pause uses x1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt_q <= ACC_WIN_W;
      mult_sh_q <= 2'd0;
      last_dn_q <= 1'b0;
    end else if (updn_calc) begin
      win_cnt_q <= 25'd0;
      mult_sh_q <= mult_sh_eff;
      last_dn_q <= (cmd_q == C_DN);
    end else if (win_cnt_q < ACC_WIN_W) begin
      win_cnt_q <= win_cnt_q + 25'd1;
    end
  end
`else
  logic unused_acc_win;
  assign unused_acc_win = ^ACC_WIN_W;
  assign step_w         = STEP_W;
`endif

  // One extra bit keeps the sum and the floor from wrapping near the top of the range.
  assign up_sum   = {1'b0, freq_q} + step_w;
  assign dn_floor = FMIN_W + step_w;
  assign up_val   = (up_sum > FMAX_W) ? FMAX_W[FW-1:0] : up_sum[FW-1:0];
  assign dn_val   = ({1'b0, freq_q} < dn_floor) ? FMIN_W[FW-1:0] : (freq_q - step_w[FW-1:0]);

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    freq_d  = freq_q;
    wave_d  = wave_q;
    amp_d   = amp_q;
    clr_vec = 4'b0000;
    case (state_q)
      S_IDLE: begin
        if (|pending_q) begin
          state_d = S_CALC;
          if (pending_q[3]) begin
            clr_vec = 4'b1000;
            cmd_d   = C_UP;
          end else if (pending_q[2]) begin
            clr_vec = 4'b0100;
            cmd_d   = C_DN;
          end else if (pending_q[1]) begin
            clr_vec = 4'b0010;
            cmd_d   = C_WAVE;
          end else begin
            clr_vec = 4'b0001;
            cmd_d   = C_AMP;
          end
        end
      end
      S_CALC: begin
        state_d = S_SEND;
        case (cmd_q)
          C_UP:    freq_d = up_val;
          C_DN:    freq_d = dn_val;
          C_WAVE:  wave_d = wave_q + 2'd1;
          default: amp_d  = amp_q + 2'd1;
        endcase
      end
      S_SEND: begin
        if (cfg_if.cfg_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A pulse landing on the bit being cleared is kept, not dropped.
    pending_d = (pending_q & ~clr_vec) | key_vec;
    drop_d    = |(key_vec & pending_q & ~clr_vec);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cmd_q     <= C_UP;
      pending_q <= 4'b0000;
      freq_q    <= FRESET_W;
      wave_q    <= 2'd0;
      amp_q     <= 2'd0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      pending_q <= pending_d;
      freq_q    <= freq_d;
      wave_q    <= wave_d;
      amp_q     <= amp_d;
      drop_q    <= drop_d;
    end
  end

  assign cfg_if.cfg_valid = (state_q == S_SEND);
  assign cfg_if.freq_word = freq_q;
  assign cfg_if.wave_sel  = wave_q;
  assign cfg_if.amp_shift = amp_q;
  assign busy_o           = (state_q != S_IDLE);
  assign drop_o           = drop_q;

endmodule
